// File: rtl/uart_receiver.sv
// UART 8N1 receiver: synchronizes uart_rx, frames bytes LSB first, hands them out on a valid/ready pair.
// Latency: data_valid rises one clk after the stop-bit sample; error pulses likewise one clk after the decision.
// Backpressure: one-byte holding register; a byte completing while the previous one is unconsumed is dropped (overrun_error).
// Optional build macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around every sample point (same timing as the default build).
module uart_receiver #(
   parameter int BAUD_RATE  = 115200,
   parameter int CLOCK_RATE = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       framing_error,
   output logic       overrun_error
);

   localparam int DIVIDER = CLOCK_RATE / BAUD_RATE;
   localparam int HALF    = DIVIDER / 2;
   localparam int CW      = $clog2(DIVIDER);
   localparam logic [CW-1:0] DIV_LAST  = CW'(DIVIDER - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          fe_wait;

   // Synchronizer taps: sync_b is the two-flop synchronized line; line_mid is
   // that line one clk later and is what the FSM acts on, so sync_b serves as
   // the "n+1" look-ahead tap for the majority vote without shifting timing.
   logic sync_a;
   logic sync_b;
   logic line_mid;
   logic sample;

   // Synchronizer and sample-window pipeline, all idle-high.
`ifdef UART_RX_MAJORITY_VOTE_EN
   logic line_past;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a    <= 1'b1;
         sync_b    <= 1'b1;
         line_mid  <= 1'b1;
         line_past <= 1'b1;
      end else begin
         sync_a    <= uart_rx;
         sync_b    <= sync_a;
         line_mid  <= sync_b;
         line_past <= line_mid;
      end
   end

   // 2-of-3 vote over counter positions n-1 (past), n (mid), n+1 (look-ahead).
   always_comb begin
      sample = (sync_b & line_mid) | (sync_b & line_past) | (line_mid & line_past);
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a   <= 1'b1;
         sync_b   <= 1'b1;
         line_mid <= 1'b1;
      end else begin
         sync_a   <= uart_rx;
         sync_b   <= sync_a;
         line_mid <= sync_b;
      end
   end

   // Single sample at the nominal point.
   always_comb begin
      sample = line_mid;
   end
`endif

   // Decode events for the current cycle.
   logic at_half;
   logic at_bit;
   logic bit_take;
   logic stop_sample;
   logic byte_done;
   logic stop_bad;
   logic cnt_clr;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // FSM next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (!line_mid) state_nx = START;
         START: if (at_half) state_nx = sample ? IDLE : DATA;
         DATA:  if (bit_take && bit_idx == 3'd7) state_nx = STOP;
         STOP: begin
            if (fe_wait) begin
               if (line_mid) state_nx = IDLE;
            end else if (stop_sample && sample) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM outputs: sample-point strobes and frame results.
   always_comb begin
      at_half     = (state == START) && (cnt == HALF_LAST);
      at_bit      = (cnt == DIV_LAST);
      bit_take    = (state == DATA) && at_bit;
      stop_sample = (state == STOP) && !fe_wait && at_bit;
      byte_done   = stop_sample && sample;
      stop_bad    = stop_sample && !sample;
      cnt_clr     = (state == IDLE) || at_half || bit_take || stop_sample;
   end

   // Bit-period counter, bit index, shift register and framing-error hold flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         bit_idx <= 3'd0;
         shift   <= 8'h00;
         fe_wait <= 1'b0;
      end else begin
         cnt <= cnt_clr ? '0 : cnt + CW'(1);
         if (at_half) begin
            bit_idx <= 3'd0;
         end else if (bit_take) begin
            bit_idx        <= bit_idx + 3'd1;
            shift[bit_idx] <= sample;
         end
         if (stop_bad)               fe_wait <= 1'b1;
         else if (state_nx != STOP)  fe_wait <= 1'b0;
      end
   end

   // Holding register with valid/ready handshake and error pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out      <= 8'h00;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
         overrun_error <= 1'b0;
      end else begin
         framing_error <= stop_bad;
         overrun_error <= byte_done && data_valid && !data_ready;
         if (byte_done && (!data_valid || data_ready)) begin
            data_out   <= shift;
            data_valid <= 1'b1;
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule
